conv_encode_param: RTL

CONV_ENCODE_PARAM -- requirements
Module: conv_encode_param

---
 rtl/conv_encode_param_pkg.sv | 30 +++
 rtl/conv_encode_param_parity.sv | 26 ++
 rtl/conv_encode_param.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/conv_encode_param_pkg.sv
// Shared definitions for the parameterised convolutional encoder:
// constraint-length limits, default generators, FSM state encoding and
// the per-pair transmit masks used by the rate-2/3 puncturing option.
package conv_encode_param_pkg;

  // Legal constraint-length range and defaults
  localparam int K_MIN     = 3;
  localparam int K_MAX     = 9;
  localparam int K_DEFAULT = 9;

  localparam int FRAME_LEN_MIN     = 1;
  localparam int FRAME_LEN_MAX     = 65535;
  localparam int FRAME_LEN_DEFAULT = 64;

  // Default generator polynomials; bit 0 taps the newest input bit
  localparam logic [K_MAX-1:0] POLY_A_DEFAULT = 9'b111101011;
  localparam logic [K_MAX-1:0] POLY_B_DEFAULT = 9'b101110001;

  // Encoder frame states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } conv_state_t;

  // Transmit masks {A,B}: phase 0 sends both bits, phase 1 drops B
  localparam logic [1:0] MASK_FULL  = 2'b11;
  localparam logic [1:0] MASK_PUNCT = 2'b10;

endpackage : conv_encode_param_pkg

// File: rtl/conv_encode_param_parity.sv
// conv_parity_core: purely combinational parity generator. Given the
// K-bit step vector v = {ShReg, bit} and the two generators it returns
// {A,B} where each output is the XOR of the tapped vector bits.
module conv_parity_core #(
  parameter int K = 9
) (
  input  logic [K-1:0] v,
  input  logic [K-1:0] poly_a,
  input  logic [K-1:0] poly_b,
  output logic [1:0]   ab
);

  logic [K-1:0] taps_a;
  logic [K-1:0] taps_b;

  // One AND per tap position; the XOR trees below fold them into A and B
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_tap
      assign taps_a[gi] = v[gi] & poly_a[gi];
      assign taps_b[gi] = v[gi] & poly_b[gi];
    end
  endgenerate

  assign ab = {^taps_a, ^taps_b};

endmodule : conv_parity_core

// File: rtl/conv_encode_param.sv
// conv_encode_param: rate-1/2 feed-forward convolutional encoder with a
// valid/ready input, a one-deep registered output and automatic K-1 zero
// tail steps per frame so the shift register returns to zero.
// Optional feature macro: CONV_PUNCT_EN (rate-2/3 puncturing through Y_mask).
module conv_encode_param
  import conv_encode_param_pkg::*;
#(
  parameter int               K         = K_DEFAULT,
  parameter logic [K_MAX-1:0] POLY_A    = POLY_A_DEFAULT,
  parameter logic [K_MAX-1:0] POLY_B    = POLY_B_DEFAULT,
  parameter int               FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         X,
  input  logic         X_valid,
  output logic         X_ready,
  output logic [1:0]   Y,
  output logic         Y_valid,
  input  logic         Y_ready,
  output logic [1:0]   Y_mask,
  output logic         Y_last,
  output logic [K-2:0] ShReg
);

  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int TAIL_W = $clog2(K);

  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [TAIL_W-1:0] TAIL_LAST  = TAIL_W'(K - 2);
  localparam logic [TAIL_W-1:0] TAIL_ONE   = TAIL_W'(1);

  // Reject illegal parameterisations at elaboration time
  generate
    if (K < K_MIN || K > K_MAX) begin : g_bad_k
      $error("conv_encode_param: K must lie in 3..9");
    end
    if (FRAME_LEN < FRAME_LEN_MIN || FRAME_LEN > FRAME_LEN_MAX) begin : g_bad_len
      $error("conv_encode_param: FRAME_LEN must lie in 1..65535");
    end
  endgenerate

  conv_state_t       state_q, state_d;
  logic [K-2:0]      sh_q, sh_d;
  logic [1:0]        y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic [1:0]        y_mask_q, y_mask_d;
  logic              y_last_q, y_last_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [TAIL_W-1:0] tail_cnt_q, tail_cnt_d;

  logic         out_free;
  logic         x_ready_int;
  logic         accept;
  logic         tail_step;
  logic         step;
  logic         step_bit;
  logic [K-1:0] step_vec;
  logic [1:0]   parity_ab;
  logic [1:0]   step_mask;

  // Handshake: the output register can be (re)loaded when empty or being drained
  always_comb begin
    out_free    = !y_valid_q || Y_ready;
    x_ready_int = !Reset && (state_q != TAIL) && out_free;
    accept      = X_valid && x_ready_int;
    tail_step   = (state_q == TAIL) && out_free;
    step        = accept || tail_step;
    step_bit    = (state_q == TAIL) ? 1'b0 : X;
    step_vec    = {sh_q, step_bit};
  end

  conv_parity_core #(
    .K (K)
  ) u_parity (
    .v      (step_vec),
    .poly_a (POLY_A[K-1:0]),
    .poly_b (POLY_B[K-1:0]),
    .ab     (parity_ab)
  );

`ifdef CONV_PUNCT_EN
  logic phase_q, phase_d;
  logic step_phase;

  // Puncture phase: every frame starts on phase 0 and flips on each step
  always_comb begin
    step_phase = (state_q == IDLE) ? 1'b0 : phase_q;
    step_mask  = step_phase ? MASK_PUNCT : MASK_FULL;
    phase_d    = phase_q;
    if (step) begin
      phase_d = ~step_phase;
    end
  end

  // Puncture phase register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  // Rate 1/2: every pair carries both coded bits
  always_comb begin
    step_mask = MASK_FULL;
  end
`endif

  // Next-state: encoder step, output register hold/drain, frame and tail counting
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    y_mask_d    = y_mask_q;
    y_last_d    = y_last_q;
    frame_cnt_d = frame_cnt_q;
    tail_cnt_d  = tail_cnt_q;

    if (step) begin
      y_d       = parity_ab;
      y_valid_d = 1'b1;
      y_mask_d  = step_mask;
      y_last_d  = 1'b0;
      sh_d      = step_vec[K-2:0];
    end else if (Y_ready) begin
      y_valid_d = 1'b0;
      y_last_d  = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          if (frame_cnt_q == FRAME_LAST) begin
            state_d     = TAIL;
            frame_cnt_d = '0;
          end else begin
            state_d     = DATA;
            frame_cnt_d = frame_cnt_q + CNT_ONE;
          end
        end
      end
      TAIL: begin
        // The final zero step loads the last pair; input reopens right after it
        if (tail_step) begin
          if (tail_cnt_q == TAIL_LAST) begin
            y_last_d   = 1'b1;
            state_d    = IDLE;
            tail_cnt_d = '0;
          end else begin
            tail_cnt_d = tail_cnt_q + TAIL_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any pending pair
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      y_mask_q    <= '0;
      y_last_q    <= 1'b0;
      frame_cnt_q <= '0;
      tail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      y_mask_q    <= y_mask_d;
      y_last_q    <= y_last_d;
      frame_cnt_q <= frame_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
    end
  end

  assign X_ready = x_ready_int;
  assign Y       = y_q;
  assign Y_valid = y_valid_q;
  assign Y_mask  = y_mask_q;
  assign Y_last  = y_last_q;
  assign ShReg   = sh_q;

endmodule : conv_encode_param
